hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It generates the stall, flush and forwarding-select controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It sequences a multi-cycle data-memory wait with a timeout watchdog, and keeps saturating stall counters for performance debug. It sits beside the datapath and drives every pipeline latch's enable and clear inputs.

## Interface
- `TIMEOUT`, default 15: maximum consecutive WAIT cycles before the memory watchdog fires (≥1).
- `CNT_W`, default 16: width of the performance counters.

- `clk` in 1: core clock; all state updates on the rising edge.
- `clr` in 1: reset, asynchronous and active-high.
- `rsD`, `rtD` in 5 each: source registers in Decode.
- `rsE`, `rtE` in 5 each: source registers in Execute.
- `writeRegE`, `writeRegM`, `writeRegW` in 5 each: destination registers per stage.
- `regWriteE`, `regWriteM`, `regWriteW` in 1 each: register write enables per stage.
- `memtoRegE`, `memtoRegM` in 1 each: the instruction is a load.
- `branchD` in 1: branch in Decode.
- `pcSrcD` in 1: branch taken.
- `jumpD` in 1: jump in Decode.
- `memReqM` in 1: load or store in Memory stage.
- `memReadyM` in 1: data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM` out 1 each: hold the PC and the IF/ID, ID/EX, EX/MEM latches.
- `flushD`, `flushE`, `flushW` out 1 each: clear the IF/ID, ID/EX, MEM/WB latches.
- `forwardAE`, `forwardBE` out 2 each: ALU operand select (00 register file, 01 WB result, 10 MEM ALU result).
- `forwardAD`, `forwardBD` out 1 each: branch comparator takes ALU result from MEM.
- `memErr` out 1: one-cycle pulse when the watchdog fires.
- `hazStallCnt`, `memStallCnt` out `CNT_W` each: saturating stall-cycle counters.

## Operation
- **Execute forwarding.**
  - `forwardAE` = 10 if `rsE`≠0, `rsE`==`writeRegM` and `regWriteM`.
  - Otherwise 01 if `rsE`≠0, `rsE`==`writeRegW` and `regWriteW`.
  - Otherwise 00. `forwardBE` follows the same rules on `rtE`. MEM has priority over WB.
- **Decode forwarding.** `forwardAD` = `rsD`≠0 && `rsD`==`writeRegM` && `regWriteM`. `forwardBD` is the same on `rtD`.
- **Load-use hazard.** `lwstall` = `memtoRegE` && (`rtE`==`rsD` || `rtE`==`rtD`).
- **Branch hazard.** `brstall` = `branchD` && ((`regWriteE` && `writeRegE`∈{`rsD`,`rtD`}) || (`memtoRegM` && `writeRegM`∈{`rsD`,`rtD`})).
- **Memory FSM.** States are IDLE, WAIT and TOUT, with a wait counter `wcnt` of width clog2(`TIMEOUT`+1).
  - `memStall` = `memReqM` && !`memReadyM` && state≠TOUT.
  - IDLE: `memStall` moves to WAIT with `wcnt`=1.
  - WAIT, `memReadyM`=1: move to IDLE.
  - WAIT, `memReadyM`=0 and `wcnt`<`TIMEOUT`: increment `wcnt`.
  - WAIT, `memReadyM`=0 and `wcnt`==`TIMEOUT`: move to TOUT.
  - WAIT, `memReqM` drops: move to IDLE.
  - TOUT always moves to IDLE. `memErr` = (state==TOUT), as a Moore output.
- **Stall and flush outputs.**
  - `stallF` = `stallD` = `lwstall` | `brstall` | `memStall`.
  - `stallE` = `stallM` = `memStall`.
  - `flushW` = `memStall`, which injects a bubble into WB.
  - `flushE` = (`lwstall` | `brstall`) & !`memStall`.
  - `flushD` = (`pcSrcD` | `jumpD`) & !`stallD`.
  - `memStall` dominates all hazard actions.
- **Counters.**
  - `hazStallCnt` increments on cycles with (`lwstall` | `brstall`) & !`memStall`.
  - `memStallCnt` increments on `memStall` cycles.
  - Both saturate at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state: zero latency.
- FSM state, `wcnt`, `memErr` and the counters are registered.
- Reset (async, immediate): state IDLE, `wcnt`=0, `memErr`=0, both counters 0. Combinational outputs track their inputs during reset.
- Watchdog, memory never ready: `TIMEOUT`+1 stall cycles (the IDLE detect cycle plus `TIMEOUT` WAIT cycles), then one TOUT cycle. In that cycle `memErr`=1 and `memStall`=0, so M/W advance with the erroneous data.
- `memReadyM` rising in WAIT releases the stall in that same cycle.
- `memReqM` with `memReadyM`=1 in IDLE: no stall and no state change.
- `clr` asserted mid-WAIT aborts the wait. The FSM returns to IDLE and `memErr` is not pulsed.
- Simultaneous `lwstall` and `brstall`: a single stall cycle, counted once.

## Structure
- Package `mips_pkg` holds the constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10, and the FSM state encoding.
- Sub-module `mem_wait_fsm` contains the FSM, `wcnt`, `memStall` and `memErr`.
- Forwarding, hazard and counter logic stay in the top level.

## Test plan
- `rsE`=5, `writeRegM`=`writeRegW`=5, `regWriteM`=`regWriteW`=1 -> `forwardAE`=10. Clear `regWriteM` -> `forwardAE`=01. `rsE`=0 -> `forwardAE`=00.
- `memtoRegE`=1, `rtE`=3, `rsD`=3 -> `stallF`=`stallD`=`flushE`=1 for one cycle and `hazStallCnt` increments by 1.
- `branchD`=1, `regWriteE`=1, `writeRegE`=`rtD`=7 -> stall with `flushE`=1. Next cycle, hazard cleared and `pcSrcD`=1 -> `flushD`=1.
- `memReqM`=1, `memReadyM` low for 3 cycles then high -> `stallM`=`flushW`=1 for exactly 3 cycles, `memStallCnt`=3, `memErr` never asserted.
- `TIMEOUT`=4, `memReadyM` held low -> 5 stall cycles, then a 1-cycle `memErr` pulse with `memStall`=0, then a new wait starts. Assert `clr` during WAIT -> FSM returns to IDLE with no `memErr` pulse.
- Force `CNT_W`=4 with 20 memory stall cycles -> `memStallCnt` saturates at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Purpose: shared constants, FSM encoding and forwarding helper for the MIPS hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // Execute-stage ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Data-memory wait sequencer states
  typedef enum logic [1:0] {
    MW_IDLE = 2'd0,
    MW_WAIT = 2'd1,
    MW_TOUT = 2'd2
  } mw_state_e;

  // Execute operand select: MEM result wins over WB; $zero is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wreg_m,
                                         input logic [4:0] wreg_w,
                                         input logic       wen_m,
                                         input logic       wen_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && src == wreg_m && wen_m) begin
      sel = FWD_MEM;
    end else if (src != 5'd0 && src == wreg_w && wen_w) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Purpose: sequences multi-cycle data-memory waits with a timeout watchdog.
// Latency: mem_stall_o is combinational; state, wait count and mem_err_o are registered.
// Backpressure: mem_stall_o holds M/W while the memory is not ready; after TIMEOUT
//   WAIT cycles one TOUT cycle releases the stall and pulses mem_err_o.
// Ports: clk/clr (async active-high), mem_req_i, mem_ready_i -> mem_stall_o, mem_err_o.
module mem_wait_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic mem_stall_o,
  output logic mem_err_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

  mw_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q;

  // The TOUT cycle deliberately drops the stall so M/W advance with the bad data.
  assign mem_stall_o = mem_req_i & ~mem_ready_i & (state_q != MW_TOUT);
  assign mem_err_o   = mem_err_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      MW_IDLE: begin
        wcnt_d = '0;
        if (mem_stall_o) begin
          state_d = MW_WAIT;
          wcnt_d  = WCNT_ONE;
        end
      end
      MW_WAIT: begin
        if (!mem_req_i || mem_ready_i) begin
          state_d = MW_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d = MW_TOUT;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      MW_TOUT: begin
        state_d = MW_IDLE;
        wcnt_d  = '0;
      end
      default: begin
        state_d = MW_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // mem_err_q mirrors (state_q == MW_TOUT) from a flop, keeping the pulse glitch-free.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= MW_IDLE;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= (state_d == MW_TOUT);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage MIPS hazard unit: forwarding selects, stall/flush for every latch, stall counters.
// Latency: forwarding/stall/flush are combinational (zero cycles); memErr and counters are registered.
// Backpressure: memory stall holds F/D/E/M and bubbles WB, overriding load-use and branch stalls.
// Ports: Decode/Execute sources, per-stage destinations and write enables, load/branch/jump flags,
//   memory request/ready -> stall*, flush*, forward*, memErr, hazStallCnt, memStallCnt.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeRegE,
  input  logic [4:0]       writeRegM,
  input  logic [4:0]       writeRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memtoRegE,
  input  logic             memtoRegM,
  input  logic             branchD,
  input  logic             pcSrcD,
  input  logic             jumpD,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             memErr,
  output logic [CNT_W-1:0] hazStallCnt,
  output logic [CNT_W-1:0] memStallCnt
);

  logic             lwstall, brstall, memStall, haz_stall;
  logic [CNT_W-1:0] haz_cnt_q, haz_cnt_d, mem_cnt_q, mem_cnt_d;

  assign forwardAE = fwd_sel(rsE, writeRegM, writeRegW, regWriteM, regWriteW);
  assign forwardBE = fwd_sel(rtE, writeRegM, writeRegW, regWriteM, regWriteW);
  assign forwardAD = (rsD != 5'd0) && (rsD == writeRegM) && regWriteM;
  assign forwardBD = (rtD != 5'd0) && (rtD == writeRegM) && regWriteM;

  assign lwstall = memtoRegE && ((rtE == rsD) || (rtE == rtD));
  // Branch resolves in Decode, so it must wait for an ALU result still in E
  // or a load result still in M.
  assign brstall = branchD &&
                   ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                    (memtoRegM && ((writeRegM == rsD) || (writeRegM == rtD))));

  mem_wait_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .clr        (clr),
    .mem_req_i  (memReqM),
    .mem_ready_i(memReadyM),
    .mem_stall_o(memStall),
    .mem_err_o  (memErr)
  );

  // While memory stalls, E is frozen too, so no bubble goes into ID/EX.
  assign haz_stall = (lwstall | brstall) & ~memStall;

  assign stallD = lwstall | brstall | memStall;
  assign stallF = stallD;
  assign stallE = memStall;
  assign stallM = memStall;
  assign flushW = memStall;
  assign flushE = haz_stall;
  assign flushD = (pcSrcD | jumpD) & ~stallD;

  always_comb begin
    haz_cnt_d = haz_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (haz_stall && !(&haz_cnt_q)) haz_cnt_d = haz_cnt_q + CNT_W'(1);
    if (memStall && !(&mem_cnt_q))  mem_cnt_d = mem_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      haz_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      haz_cnt_q <= haz_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign hazStallCnt = haz_cnt_q;
  assign memStallCnt = mem_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [4:0]    rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic          regWriteE, regWriteM, regWriteW, memtoRegE, memtoRegM;
  logic          branchD, pcSrcD, jumpD, memReqM, memReadyM;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0]    forwardAE, forwardBE;
  logic          forwardAD, forwardBD, memErr;
  logic [CW-1:0] hazStallCnt, memStallCnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM),
    .branchD(branchD), .pcSrcD(pcSrcD), .jumpD(jumpD),
    .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .memErr(memErr), .hazStallCnt(hazStallCnt), .memStallCnt(memStallCnt)
  );

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic rwE, rwM, rwW, mtrE, mtrM, br, pc, jp, mq, mr;
    logic [1:0] fAE, fBE;
    logic fAD, fBD, stF, stE, flD, flE, flW;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_pass = 0;
  int exp_haz, exp_mem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mkv(
      input logic [4:0] a_rsD, a_rtD, a_rsE, a_rtE, a_wE, a_wM, a_wW,
      input logic a_rwE, a_rwM, a_rwW, a_mtrE, a_mtrM, a_br, a_pc, a_jp, a_mq, a_mr,
      input logic [1:0] e_fAE, e_fBE,
      input logic e_fAD, e_fBD, e_stF, e_stE, e_flD, e_flE, e_flW);
    vec_t t;
    t = {a_rsD, a_rtD, a_rsE, a_rtE, a_wE, a_wM, a_wW,
         a_rwE, a_rwM, a_rwW, a_mtrE, a_mtrM, a_br, a_pc, a_jp, a_mq, a_mr,
         e_fAE, e_fBE, e_fAD, e_fBD, e_stF, e_stE, e_flD, e_flE, e_flW};
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rsD = t.rsD; rtD = t.rtD; rsE = t.rsE; rtE = t.rtE;
    writeRegE = t.wE; writeRegM = t.wM; writeRegW = t.wW;
    regWriteE = t.rwE; regWriteM = t.rwM; regWriteW = t.rwW;
    memtoRegE = t.mtrE; memtoRegM = t.mtrM;
    branchD = t.br; pcSrcD = t.pc; jumpD = t.jp;
    memReqM = t.mq; memReadyM = t.mr;
  endtask

  task automatic zero_in();
    drive('0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    zero_in();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            rsD rtD rsE rtE wE wM wW  rwE rwM rwW mtE mtM br pc jp mq mr | fAE fBE fAD fBD stF stE flD flE flW
    vecs[0]  = mkv(0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(0,  0,  5,  0,  0, 5, 5,  0,  1,  1,  0,  0,  0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(0,  0,  5,  0,  0, 5, 5,  0,  0,  1,  0,  0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mkv(0,  0,  0,  0,  0, 5, 5,  0,  1,  1,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkv(0,  0,  9,  9,  0, 9, 0,  0,  1,  0,  0,  0,  0, 0, 0, 0, 0,  2, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(0,  0,  7,  6,  0, 7, 6,  0,  1,  1,  0,  0,  0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mkv(0,  0,  4,  4,  0, 4, 4,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(8,  8,  0,  0,  0, 8, 0,  0,  1,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(0,  0,  0,  0,  0, 0, 0,  0,  1,  1,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(3,  0,  0,  3,  0, 0, 0,  0,  0,  0,  1,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[10] = mkv(1, 12,  0, 12,  0, 0, 0,  0,  0,  0,  1,  0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[11] = mkv(1,  2,  0, 12,  0, 0, 0,  0,  0,  0,  1,  0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[12] = mkv(1,  7,  0,  0,  7, 0, 0,  1,  0,  0,  0,  0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[13] = mkv(1,  7,  0,  0,  7, 0, 0,  0,  0,  0,  0,  0,  1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[14] = mkv(10, 0,  0,  0,  0,10, 0,  0,  0,  0,  0,  1,  1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[15] = mkv(10, 0,  0,  0,  0,10, 0,  0,  0,  0,  0,  1,  0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[16] = mkv(7,  0,  0,  7,  7, 0, 0,  1,  0,  0,  1,  0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[17] = mkv(0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mkv(3,  0,  0,  3,  0, 0, 0,  0,  0,  0,  1,  0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[19] = mkv(0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset: registered state cleared, combinational forwarding still live.
    zero_in();
    clr = 1'b1;
    rsE = 5; writeRegM = 5; regWriteM = 1'b1;
    @(negedge clk);
    chk("rst_hazcnt", hazStallCnt, 0);
    chk("rst_memcnt", memStallCnt, 0);
    chk("rst_memerr", memErr, 0);
    chk("rst_fwdAE_comb", forwardAE, 2);
    @(posedge clk); #1;
    clr = 1'b0;
    zero_in();

    // Table vectors, one cycle each.
    exp_haz = 0;
    exp_mem = 0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_fwdAE", i), forwardAE, vecs[i].fAE);
      chk($sformatf("v%0d_fwdBE", i), forwardBE, vecs[i].fBE);
      chk($sformatf("v%0d_fwdAD", i), forwardAD, vecs[i].fAD);
      chk($sformatf("v%0d_fwdBD", i), forwardBD, vecs[i].fBD);
      chk($sformatf("v%0d_stallF", i), stallF, vecs[i].stF);
      chk($sformatf("v%0d_stallD", i), stallD, vecs[i].stF);
      chk($sformatf("v%0d_stallE", i), stallE, vecs[i].stE);
      chk($sformatf("v%0d_stallM", i), stallM, vecs[i].stE);
      chk($sformatf("v%0d_flushD", i), flushD, vecs[i].flD);
      chk($sformatf("v%0d_flushE", i), flushE, vecs[i].flE);
      chk($sformatf("v%0d_flushW", i), flushW, vecs[i].flW);
      // Counters at this point include every earlier vector's cycle.
      chk($sformatf("v%0d_hazcnt", i), hazStallCnt, exp_haz);
      chk($sformatf("v%0d_memcnt", i), memStallCnt, exp_mem);
      exp_haz += int'(vecs[i].flE);
      exp_mem += int'(vecs[i].flW);
    end
    chk("tbl_memerr", memErr, 0);

    // Memory wait of 3 cycles, then ready releases in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      memReqM = 1'b1; memReadyM = 1'b0;
      @(negedge clk);
      chk($sformatf("w3_c%0d_stallM", i), stallM, 1);
      chk($sformatf("w3_c%0d_flushW", i), flushW, 1);
      chk($sformatf("w3_c%0d_stallF", i), stallF, 1);
      chk($sformatf("w3_c%0d_memErr", i), memErr, 0);
    end
    @(posedge clk); #1;
    memReadyM = 1'b1;
    @(negedge clk);
    chk("w3_ready_stallM", stallM, 0);
    chk("w3_ready_flushW", flushW, 0);
    chk("w3_ready_memErr", memErr, 0);
    @(posedge clk); #1;
    memReqM = 1'b0; memReadyM = 1'b0;
    @(negedge clk);
    chk("w3_memcnt", memStallCnt, 3);
    chk("w3_done_memErr", memErr, 0);

    // Watchdog with memory never ready: 5 stalls, 1 error cycle, repeat; counter saturates.
    do_reset();
    @(posedge clk); #1;
    memReqM = 1'b1; memReadyM = 1'b0;
    for (int i = 0; i < 27; i++) begin
      logic e_err;
      if (i != 0) @(negedge clk);
      else @(negedge clk);
      e_err = ((i % 6) == 5);
      chk($sformatf("wd_c%0d_stallM", i), stallM, !e_err);
      chk($sformatf("wd_c%0d_stallF", i), stallF, !e_err);
      chk($sformatf("wd_c%0d_memErr", i), memErr, e_err);
      if (i == 6) chk("wd_memcnt_first", memStallCnt, 5);
    end
    chk("wd_memcnt_sat", memStallCnt, 15);
    chk("wd_hazcnt", hazStallCnt, 0);

    // Reset in the middle of a wait aborts it without an error pulse.
    do_reset();
    @(posedge clk); #1;
    memReqM = 1'b1; memReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("cw_c%0d_stallM", i), stallM, 1);
    end
    #2;
    clr = 1'b1;
    #1;
    chk("cw_clr_memErr", memErr, 0);
    chk("cw_clr_memcnt", memStallCnt, 0);
    chk("cw_clr_stall_comb", stallM, 1);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("cw_post%0d_stallM", i), stallM, 1);
      chk($sformatf("cw_post%0d_memErr", i), memErr, 0);
    end
    chk("cw_post_memcnt", memStallCnt, 4);
    @(posedge clk); #1;
    memReqM = 1'b0;
    @(negedge clk);
    chk("cw_idle_stallM", stallM, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
